// File: rtl/uart_pkg.sv
// uart_pkg: types and constants shared by the UART receive and transmit cores.
//   uartState_t : receiver frame state
//   OVS         : oversampling factor (ticks per bit)
//   MID_TICK    : tick count from the start edge to the middle of the start bit
//   calcDiv()   : clocks per oversample tick, integer-truncated
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uartState_t;

  localparam int OVS      = 16;
  localparam int MID_TICK = 8;

  // Clocks per oversample tick; the transmit core uses the same divider value.
  function automatic int calcDiv(input int clkFreq, input int bps, input int ovs);
    return clkFreq / (bps * ovs);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: oversample tick generator.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   clr  : holds the divider at zero so the first tick lands DIV clocks after release
//   tick : one-cycle pulse every DIV clocks while clr is low
module uart_baud_tick #(
  parameter int DIV = 651
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Divider counter with registered tick on wrap.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == LAST) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + CW'(1);
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 UART receiver with 16x oversampling.
//   clk      : system clock, rising edge
//   rst      : synchronous active-high reset
//   rxIn     : asynchronous serial line, idles high
//   data     : last correctly framed byte (LSB received first)
//   valid    : one-cycle strobe, data is new this cycle
//   frameErr : one-cycle strobe, stop bit sampled low (data left unchanged)
//   busy     : high while a frame is in progress
module uart_rx_core #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BPS      = 9600,
  parameter int OVS      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxIn,
  output logic [7:0] data,
  output logic       valid,
  output logic       frameErr,
  output logic       busy
);

  import uart_pkg::*;

  localparam int         DIV       = calcDiv(CLK_FREQ, BPS, OVS);
  localparam logic [3:0] LAST_TICK = 4'(OVS - 1);
  localparam logic [3:0] MID_LAST  = 4'(MID_TICK - 1);

  uartState_t state;
  logic       rxMeta;
  logic       rxS;
  logic       tick;
  logic       tickClr;
  logic [3:0] tc;
  logic [2:0] bitIdx;
  logic [7:0] shiftReg;

  // Two-flop synchronizer; idles high so reset does not look like a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rxMeta <= 1'b1;
      rxS    <= 1'b1;
    end else begin
      rxMeta <= rxIn;
      rxS    <= rxMeta;
    end
  end

  // Divider is held in IDLE so every frame's ticks are phase-aligned to its start edge.
  assign tickClr = (state == IDLE);

  uart_baud_tick #(
    .DIV (DIV)
  ) uBaudTick (
    .clk  (clk),
    .rst  (rst),
    .clr  (tickClr),
    .tick (tick)
  );

  // Frame FSM with registered strobes and busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tc       <= 4'd0;
      bitIdx   <= 3'd0;
      shiftReg <= 8'h00;
      data     <= 8'h00;
      valid    <= 1'b0;
      frameErr <= 1'b0;
      busy     <= 1'b0;
    end else begin
      valid    <= 1'b0;
      frameErr <= 1'b0;
      case (state)
        IDLE: begin
          tc     <= 4'd0;
          bitIdx <= 3'd0;
          if (!rxS) begin
            state <= START;
            busy  <= 1'b1;
          end else begin
            busy  <= 1'b0;
          end
        end
        START: begin
          if (tick) begin
            if (tc == MID_LAST) begin
              tc     <= 4'd0;
              bitIdx <= 3'd0;
              if (!rxS) begin
                state <= DATA;
              end else begin
                // Line went back high before mid start bit: glitch, not a frame.
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              tc <= tc + 4'd1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (tc == LAST_TICK) begin
              tc       <= 4'd0;
              // Shift in at the MSB: after 8 bits the first bit received sits at bit 0.
              shiftReg <= {rxS, shiftReg[7:1]};
              if (bitIdx == 3'd7) begin
                state <= STOP;
              end else begin
                bitIdx <= bitIdx + 3'd1;
              end
            end else begin
              tc <= tc + 4'd1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (tc == LAST_TICK) begin
              tc <= 4'd0;
              // Leaving at mid stop bit gives back-to-back frames no dead time.
              if (rxS) begin
                data  <= shiftReg;
                valid <= 1'b1;
                state <= IDLE;
                busy  <= 1'b0;
              end else begin
                frameErr <= 1'b1;
                state    <= BREAK;
              end
            end else begin
              tc <= tc + 4'd1;
            end
          end
        end
        BREAK: begin
          // A line held low must not be mistaken for a new start bit.
          if (rxS) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
- Serial UART receiver; the receive-side counterpart of the existing 8N1 transmit core in the uart subsystem.
- Samples the asynchronous rxIn line with 16x oversampling and checks start and stop framing.
- Presents each received byte on data with a one-cycle valid strobe.
- Feeds a downstream command parser, e.g. RTC time-set.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BPS, 9600, baud rate in bits per second.
- OVS, 16, oversampling factor; fixed at 16 and not meant to be overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- rxIn  input  1  asynchronous serial line; idles high.
- data  output  8  last correctly framed byte, LSB received first.
- valid  output  1  one-cycle strobe; data is new this cycle.
- frameErr  output  1  one-cycle strobe; the stop bit was sampled low.
- busy  output  1  high while a frame is in progress (state not IDLE).

Behaviour:
- Clock and reset:
  - One clock domain: clk.
  - Reset is synchronous, active-high, on rst.
- Reset values:
  - data = 8'h00; valid = 0; frameErr = 0; busy = 0.
  - Synchronizer flops = 1; state = IDLE; all counters = 0.
- Input synchronizer:
  - rxIn passes through a 2-FF synchronizer; rxS is the second stage.
  - All decisions use rxS only.
- Oversample tick generator:
  - DIV = CLK_FREQ / (BPS*OVS), integer truncation. Default DIV = 651.
  - tick pulses one cycle every DIV clocks.
  - The counter free-runs in all states except IDLE.
  - In IDLE it is held at 0, so a frame's ticks are phase-aligned to the start edge.
- FSM state IDLE:
  - busy = 0.
  - On rxS == 0: go to START and clear the tick-count register tc.
- FSM state START:
  - Count ticks.
  - On the 8th tick (mid start bit): if rxS == 0, go to DATA with tc = 0 and bit index = 0.
  - If rxS == 1 at that point it is a false start: return to IDLE with no strobe.
- FSM state DATA:
  - On every 16th tick, shift rxS into the shift register MSB. After 8 bits the LSB-first byte is aligned.
  - After bit index 7: go to STOP.
- FSM state STOP:
  - On the 16th tick (mid stop bit), sample rxS.
  - rxS == 1: data <= shift register; valid = 1 for exactly one clk; go to IDLE.
  - rxS == 0: frameErr = 1 for one clk; data is unchanged; go to BREAK.
- FSM state BREAK:
  - Wait until rxS == 1, then go to IDLE.
  - This prevents a held-low line from re-triggering a start.
- valid and frameErr are never asserted in the same cycle.
- busy = 1 in START, DATA, STOP and BREAK.
- Latency:
  - From the rxIn falling edge to valid: 2 sync cycles + (8 + 16*9) * DIV clocks.
  - With defaults that is about 9.5 bit times = 98,954 cycles.
- Back-to-back frames:
  - The return to IDLE happens at mid stop bit.
  - The next start edge is therefore accepted with no dead time.
- Reset mid-frame:
  - Returns to IDLE immediately.
  - The partial byte is discarded; no strobe is issued.
- No flow control: data is overwritten only by the next good frame. The consumer must capture data on valid.

Decomposition:
- Package uart_pkg holds:
  - State enum {IDLE, START, DATA, STOP, BREAK}.
  - OVS = 16 and MID_TICK = 8.
  - A function computing DIV from CLK_FREQ and BPS. The transmit core reuses the DIV computation.
- One sub-module: uart_baud_tick.
  - Parameterized divider with ports clk, rst, clr, tick.
  - Instanced here with clr held while the FSM is in IDLE.

Test Plan:
- Send byte 8'hA5 at 9600 bps with defaults.
  - valid pulses once, exactly 1 cycle; data = 8'hA5; frameErr stays 0.
  - busy falls in the same cycle valid rises.
- Send 8'h00, then 8'hFF, back-to-back with one stop bit each.
  - Two valid pulses with data 8'h00 then 8'hFF; no frameErr.
- Glitch: drive rxIn low for 3*DIV clocks, then high.
  - FSM returns to IDLE; valid and frameErr stay 0.
- Send 8'h3C with the stop bit forced low, then hold rxIn low for 2 bit times, then high.
  - One frameErr pulse; data keeps its previous value.
  - busy stays 1 until rxIn returns high; no spurious valid.
- Assert rst for 1 cycle during data bit 4 of 8'h5A.
  - All outputs at reset values next cycle.
  - A following clean 8'h81 frame gives valid with data = 8'h81.
- Set BPS = 115200 and CLK_FREQ = 50_000_000 (DIV = 27); send 8'hC3.
  - data = 8'hC3; sampling stays correct with ±2% baud mismatch injected on rxIn.
